dram_arbiter: RTL

//   Shares the single-port DRAM (registered-address synchronous RAM, 1 port) between two

---
 rtl/dram_pkg.sv | 21 ++
 rtl/dram_rd_tag_pipe.sv | 54 +++++
 rtl/dram_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared types and constants for the two-requester DRAM arbiter and its read-return pipe.
package dram_pkg;

  localparam int unsigned DRAM_DATA_W = 32;
  localparam int unsigned DRAM_ADDR_W = 12;
  localparam int unsigned DRAM_RD_LAT = 3;
  // One tag stage per cycle between ack and the rdata register.
  localparam int unsigned TAG_STAGES  = DRAM_RD_LAT - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } owner_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/dram_rd_tag_pipe.sv
// Tracks which requester issued each in-flight read and returns DRAM data to it
// with a registered rdata/rvalid stage.
module dram_rd_tag_pipe
  import dram_pkg::*;
#(
  parameter int unsigned DATA_W = DRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_valid,
  input  logic              i_load_id,
  input  logic [DATA_W-1:0] i_mem_q,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata
);

  rd_tag_t           r_tag_s0;
  rd_tag_t           r_tag_s1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata;

  // Tag shift: stage 0 lines up with the DRAM address cycle, stage 1 with mem_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_s0 <= '0;
      r_tag_s1 <= '0;
    end else begin
      r_tag_s0 <= rd_tag_t'{valid: i_load_valid, id: i_load_id};
      r_tag_s1 <= r_tag_s0;
    end
  end

  // rdata only updates on a returning read so it holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid0 <= r_tag_s1.valid & ~r_tag_s1.id;
      r_rvalid1 <= r_tag_s1.valid &  r_tag_s1.id;
      if (r_tag_s1.valid) begin
        r_rdata <= i_mem_q;
      end
    end
  end

  assign o_rvalid0 = r_rvalid0;
  assign o_rvalid1 = r_rvalid1;
  assign o_rdata   = r_rdata;

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one single-port DRAM between
// instruction fetch (req 0) and the load/store unit (req 1).
module dram_arbiter
  import dram_pkg::*;
#(
  parameter int unsigned DATA_W    = DRAM_DATA_W,
  parameter int unsigned ADDR_W    = DRAM_ADDR_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  owner_e            r_state;
  owner_e            w_state_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [CNT_W-1:0]  w_burst_cnt_nxt;

  logic              w_grant;
  logic              w_gid;
  logic              w_burst_open;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;

  assign w_burst_open = (r_burst_cnt < BURST_LIMIT);

  // Owner state, last winner and burst count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Winner selection and next-state; an owner keeps the port until its burst
  // budget runs out, but only while the other side is actually waiting.
  always_comb begin
    w_grant         = 1'b0;
    w_gid           = 1'b0;
    w_state_nxt     = ST_IDLE;
    w_last_nxt      = r_last;
    w_burst_cnt_nxt = '0;

    case (r_state)
      ST_OWN0: begin
        if (req0 && (w_burst_open || !req1)) begin
          w_grant = 1'b1;
          w_gid   = 1'b0;
        end else if (req1) begin
          w_grant = 1'b1;
          w_gid   = 1'b1;
        end
      end
      ST_OWN1: begin
        if (req1 && (w_burst_open || !req0)) begin
          w_grant = 1'b1;
          w_gid   = 1'b1;
        end else if (req0) begin
          w_grant = 1'b1;
          w_gid   = 1'b0;
        end
      end
      default: begin
        if (req0 && req1) begin
          w_grant = 1'b1;
          w_gid   = ~r_last;
        end else if (req0) begin
          w_grant = 1'b1;
          w_gid   = 1'b0;
        end else if (req1) begin
          w_grant = 1'b1;
          w_gid   = 1'b1;
        end
      end
    endcase

    if (!rst_n) begin
      w_grant = 1'b0;
    end

    if (w_grant) begin
      w_state_nxt = w_gid ? ST_OWN1 : ST_OWN0;
      w_last_nxt  = w_gid;
      if (r_state == w_state_nxt) begin
        w_burst_cnt_nxt = (r_burst_cnt == BURST_LIMIT) ? r_burst_cnt
                                                       : r_burst_cnt + CNT_W'(1);
      end else begin
        w_burst_cnt_nxt = CNT_W'(1);
      end
    end
  end

  assign ack0 = w_grant & ~w_gid;
  assign ack1 = w_grant &  w_gid;

  assign w_sel_we   = w_gid ? we1    : we0;
  assign w_sel_addr = w_gid ? addr1  : addr0;
  assign w_sel_data = w_gid ? wdata1 : wdata0;

  // Command register toward the DRAM; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_mem_we <= w_grant & w_sel_we;
      if (w_grant) begin
        r_mem_addr <= w_sel_addr;
        r_mem_data <= w_sel_data;
      end
    end
  end

  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;

  dram_rd_tag_pipe #(
    .DATA_W (DATA_W)
  ) u_rd_tag_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_valid (w_grant & ~w_sel_we),
    .i_load_id    (w_gid),
    .i_mem_q      (mem_q),
    .o_rvalid0    (rvalid0),
    .o_rvalid1    (rvalid1),
    .o_rdata      (rdata)
  );

endmodule
